// File: rtl/subservient_uart_loader.sv
// UART boot loader: 8N1 bytes -> length-prefixed little-endian words -> single-outstanding Wishbone writes.
// Write strobe rises one cycle after the fourth byte; a word finishing while a write is pending is dropped and flagged.
module subservient_uart_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADR     = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_uart_rx,
    output logic        o_debug_mode,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic [31:0] i_wb_dbg_rdt,
    input  logic        i_wb_dbg_ack,
    output logic        o_done,
    output logic        o_frame_err,
    output logic        o_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LEN0, LEN1, DATA, FINISH} ld_state_t;
    typedef enum logic       {W_IDLE, W_BUSY} w_state_t;

    logic unused_rdt;
    assign unused_rdt = ^i_wb_dbg_rdt;

    logic            rx_meta_q, rx_sync_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tick, byte_vld, frame_err_set;

    ld_state_t       ld_state_q, ld_state_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     words_q, words_d;
    logic [1:0]      bpos_q, bpos_d;
    logic [23:0]     word_q, word_d;
    logic            handoff;

    w_state_t        w_state_q, w_state_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic            frame_err_q, overrun_q, overrun_set;

    assign tick = (cnt_q == CW'(1));

    always_comb begin
        rx_state_d    = rx_state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        byte_vld      = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = HALF;
                end
            end
            RX_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    cnt_d      = FULL;
                    bit_d      = 3'd0;
                end
            end
            RX_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            default: begin
                if (!tick) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_vld = 1'b1;
                    end else begin
                        frame_err_set = 1'b1;
                    end
                end
            end
        endcase
    end

    // Once all N words are handed off, finish when the write in flight is acknowledged.
    always_comb begin
        ld_state_d = ld_state_q;
        len_d      = len_q;
        words_d    = words_q;
        bpos_d     = bpos_q;
        word_d     = word_q;
        handoff    = 1'b0;
        case (ld_state_q)
            LEN0: begin
                if (byte_vld) begin
                    len_d[7:0] = shift_q;
                    ld_state_d = LEN1;
                end
            end
            LEN1: begin
                if (byte_vld) begin
                    len_d[15:8] = shift_q;
                    ld_state_d  = ({shift_q, len_q[7:0]} == 16'd0) ? FINISH : DATA;
                end
            end
            DATA: begin
                if (words_q == len_q) begin
                    if ((w_state_q == W_IDLE) || i_wb_dbg_ack) begin
                        ld_state_d = FINISH;
                    end
                end else if (byte_vld) begin
                    if (bpos_q == 2'd3) begin
                        handoff = 1'b1;
                        words_d = words_q + 16'd1;
                        bpos_d  = 2'd0;
                    end else begin
                        word_d = {shift_q, word_q[23:8]};
                        bpos_d = bpos_q + 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_d   = w_state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        overrun_set = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (handoff) begin
                    adr_d     = BASE_ADR + {14'd0, words_q, 2'b00};
                    dat_d     = {shift_q, word_q};
                    w_state_d = W_BUSY;
                end
            end
            default: begin
                overrun_set = handoff;
                if (i_wb_dbg_ack) begin
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            ld_state_q  <= LEN0;
            len_q       <= 16'd0;
            words_q     <= 16'd0;
            bpos_q      <= 2'd0;
            word_q      <= 24'd0;
            w_state_q   <= W_IDLE;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= i_uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ld_state_q  <= ld_state_d;
            len_q       <= len_d;
            words_q     <= words_d;
            bpos_q      <= bpos_d;
            word_q      <= word_d;
            w_state_q   <= w_state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            frame_err_q <= frame_err_q | frame_err_set;
            overrun_q   <= overrun_q | overrun_set;
        end
    end

    assign o_wb_dbg_stb = (w_state_q == W_BUSY);
    assign o_wb_dbg_adr = adr_q;
    assign o_wb_dbg_dat = dat_q;
    assign o_wb_dbg_sel = 4'hF;
    assign o_wb_dbg_we  = 1'b1;
    assign o_done       = (ld_state_q == FINISH);
    assign o_debug_mode = (ld_state_q != FINISH);
    assign o_frame_err  = frame_err_q;
    assign o_overrun    = overrun_q;

endmodule

// File: doc/subservient_uart_loader.md
# subservient_uart_loader

Boot loader that sits directly upstream of the subservient SoC's debug Wishbone port. It receives a program image over a UART line and writes it word by word into SRAM through the debug interface, holding the core in debug mode while it does so. When the last word has been acknowledged it releases debug mode so the core starts executing. It has one UART receiver, a byte-to-word assembler and a single-outstanding Wishbone write master.

## Interface
- CLKS_PER_BIT, default 868: i_clk cycles per UART bit; minimum 4.
- BASE_ADR, default 32'h0: byte address of the first word written.
- i_clk  in  1  system clock; all logic is rising-edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_uart_rx  in  1  UART RX line; 8N1 framing, LSB first, idle high; asynchronous to i_clk.
- o_debug_mode  out  1  high while loading; high during reset; low once loading is finished.
- o_wb_dbg_adr  out  32  write address.
- o_wb_dbg_dat  out  32  write data, little-endian assembled.
- o_wb_dbg_sel  out  4  constant 4'hF.
- o_wb_dbg_we  out  1  constant 1.
- o_wb_dbg_stb  out  1  write request strobe.
- i_wb_dbg_rdt  in  32  ignored.
- i_wb_dbg_ack  in  1  single-cycle write acknowledge.
- o_done  out  1  high from load completion until reset.
- o_frame_err  out  1  sticky; set on a bad stop bit.
- o_overrun  out  1  sticky; set when a word completes while a write is still pending.

## Operation
- **RX synchroniser.** A 2-flop synchroniser on i_uart_rx; both flops reset to 1.
- **RX FSM.** States RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE -> RX_START when the synchronised line is 0. Load the bit counter with CLKS_PER_BIT/2 (integer division).
  - RX_START at counter expiry: if the line is 0, go to RX_DATA; if the line is 1 (glitch), return to RX_IDLE with no error.
  - RX_DATA samples every CLKS_PER_BIT cycles, shifting 8 bits in LSB first.
  - RX_STOP samples after a further CLKS_PER_BIT cycles. If the sample is 1, pulse byte_valid for one cycle. If it is 0, set o_frame_err and discard the byte.
  - Return to RX_IDLE in the same cycle as the stop sample.
- **Load FSM.** States LEN0, LEN1, DATA, FINISH.
  - LEN0 takes the low byte of the 16-bit word count N. LEN1 takes the high byte.
  - After LEN1: if N==0, go directly to FINISH; otherwise go to DATA.
  - In DATA, bytes fill a 32-bit word little-endian: the first byte goes to [7:0] and the fourth to [31:24].
  - On the fourth byte the word is handed to the write master and the word counter increments.
  - After handing off word N, the Load FSM waits for its ack, then enters FINISH.
  - FINISH: o_debug_mode=0 and o_done=1 until reset. Further RX bytes are received but ignored; o_frame_err still updates.
- **Write master.** States W_IDLE, W_BUSY.
  - W_IDLE on handoff: latch adr = BASE_ADR + 4*index (mod 2^32, wraps silently) and dat; assert stb; enter W_BUSY.
  - W_BUSY: stb held, with adr and dat stable, until a cycle with ack=1. stb is low in the following cycle; return to W_IDLE.
  - If a word completes while in W_BUSY, set o_overrun and drop the new word. The index still increments, so later addresses are unchanged.
- **Frame errors.** A frame error does not resynchronise the Load FSM; the image is corrupt and o_frame_err flags it to the host.
- **Reset.**
  - Reset value 0: o_wb_dbg_stb, o_done, o_frame_err, o_overrun, o_wb_dbg_adr, o_wb_dbg_dat.
  - Reset value 1: o_debug_mode.
  - Constants: o_wb_dbg_sel=4'hF, o_wb_dbg_we=1.
  - Reset mid-load or mid-write drops stb asynchronously and returns all FSMs to RX_IDLE/LEN0/W_IDLE. A reload restarts from BASE_ADR.

## Timing
- **Byte timing.** Let t0 be the first cycle the synchronised line is 0 in RX_IDLE.
  - Start check at t0 + CLKS_PER_BIT/2.
  - Data bit k sampled at t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
  - byte_valid at t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
- **Line latency.** i_uart_rx to synchronised line: 2 cycles.
- **Write latency.** The fourth-byte byte_valid cycle is T; o_wb_dbg_stb is high from T+1. The earliest ack is at T+1 (stb high for 1 cycle).
- **Completion.** Final ack in cycle A: o_debug_mode falls and o_done rises at A+1.
- **Back-to-back.** A start edge may be detected the cycle after the stop sample. Back-to-back frames have no gap requirement beyond the stop bit.

## Test plan
- **Normal load.** CLKS_PER_BIT=4, BASE_ADR=0. Send 02 00 78 56 34 12 EF BE AD DE, ack 1 cycle after stb.
  - Required: writes adr 0x0 dat 0x12345678, then adr 0x4 dat 0xDEADBEEF, sel=F, we=1.
  - o_done=1 and o_debug_mode=0 one cycle after the second ack.
- **Zero length.** Send 00 00 -> no stb ever; o_done rises one cycle after the LEN1 byte_valid.
- **Slow ack.** Ack delayed 20 cycles -> stb, adr and dat stable for 20 cycles; stb low the cycle after ack; no overrun.
- **Bad stop bit.** One byte with stop=0 -> o_frame_err=1 and stays 1. A 1-cycle low glitch shorter than CLKS_PER_BIT/2 -> no byte, no error.
- **Overrun.** Withhold ack across two words -> o_overrun=1; the next write after the ack uses adr BASE_ADR+8.
- **Reset mid-write.** Assert i_rst while stb=1 -> stb=0 immediately, o_debug_mode=1. A full reload then writes adr BASE_ADR first.
